sparse_chunk_sram: RTL
======================

Name: sparse_chunk_sram

Overview:
- Synthesizable SRAM stage that consumes the chunked sparse write stream (sparsemap plus packed non-zero data, one bus beat per cycle) produced by the IFM/filter memory generator.
- Stores the stream per chunk and serves beat-granular reads to the downstream compute/prefetch logic.
- Tracks per chunk: beats written, total non-zero count (popcount of the sparsemap), and a ready flag.
- Detects malformed write sequences.
- One instance is used for IFM and one for filter.

Parameters:
- BUS_SIZE, 64: bits of sparsemap per beat; packed data per beat is BUS_SIZE*DAT_SIZE.
- DAT_SIZE, 8: bits per data element.
- WR_DAT_CYC_NUM, 4: maximum beats per chunk.
- CHUNK_NUM, 32: number of chunks stored.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- clr_i  in  1  synchronous clear of ready flags, beat counts, nz counts and error; memory contents are kept.
- wr_valid_i  in  1  write beat valid.
- wr_sparsemap_i  in  BUS_SIZE  sparsemap slice for this beat.
- wr_nonzero_data_i  in  BUS_SIZE*DAT_SIZE  packed non-zero data slice.
- wr_dat_count_i  in  clog2(WR_DAT_CYC_NUM)  beat index within chunk.
- wr_chunk_count_i  in  clog2(CHUNK_NUM)  target chunk.
- rd_req_i  in  1  read request.
- rd_chunk_i  in  clog2(CHUNK_NUM)  read chunk.
- rd_dat_count_i  in  clog2(WR_DAT_CYC_NUM)  read beat.
- rd_valid_o  out  1  read data valid.
- rd_sparsemap_o  out  BUS_SIZE  read sparsemap.
- rd_nonzero_data_o  out  BUS_SIZE*DAT_SIZE  read data.
- rd_nz_count_o  out  clog2(BUS_SIZE*WR_DAT_CYC_NUM+1)  total non-zeros in the read chunk.
- rd_hit_o  out  1  read chunk was ready at request time.
- chunk_ready_o  out  CHUNK_NUM  per-chunk ready bitmap.
- wr_err_o  out  1  sticky sequence error.

Behaviour:
- **Reset** (rst_i=0 at posedge): all outputs 0, ready bitmap 0, beat counts 0, nz counts 0, open-chunk tracker idle. Memory contents are undefined and not cleared. Reset mid-stream discards the open chunk.
- **Memory address:** addr = chunk*WR_DAT_CYC_NUM + dat_count. Two arrays: sparsemap and data. Each has 1 write port and 1 read port.
- **Open-chunk tracker:** registers open_vld, open_chunk, last_beat, nz_acc.
- **Beat write** (wr_valid_i=1), in the same posedge:
  - Memory word is written.
  - If wr_dat_count_i==0: nz_acc = popcount(wr_sparsemap_i), and ready[chunk] is cleared. A rewrite invalidates the chunk.
  - Otherwise: nz_acc += popcount.
  - open_chunk, last_beat and open_vld are updated.
- **Chunk close:** the open chunk closes when open_vld=1 and either:
  - wr_valid_i=0, or
  - wr_valid_i=1 with wr_chunk_count_i != open_chunk.

  On close, the following are committed to open_chunk's per-chunk registers in the same cycle: beat_cnt = last_beat+1, nz_cnt = nz_acc, ready=1. chunk_ready_o updates the cycle after the close edge.
- **Simultaneous close and new-chunk beat 0:** both are handled in the same cycle. The old chunk commits and the new chunk opens.
- **Sequence error:** wr_err_o is set (sticky until reset/clr_i) if a beat has dat_count != 0 and is not (same chunk and dat_count == last_beat+1) with open_vld=1. The beat is still written; the chunk closes normally.
- **Read:**
  - Latency is 1 cycle. rd_valid_o is registered rd_req_i; other rd_* outputs are valid when rd_valid_o=1 and hold their value otherwise.
  - If rd_dat_count_i >= beat_cnt[rd_chunk_i], rd_sparsemap_o and rd_nonzero_data_o are forced to 0. This makes short final chunks read as zero padding.
  - rd_nz_count_o = nz_cnt[rd_chunk_i]; rd_hit_o = ready[rd_chunk_i], both sampled at the request edge.
- **Read/write collision** (same address, same cycle): the read returns the old word (read-before-write). Per-chunk registers are also sampled pre-update.
- **clr_i:**
  - Has lower priority than rst_i and higher priority than a close in the same cycle. The pending commit is dropped.
  - A write beat in the same cycle is still stored and opens/continues the tracker.
- **Widths:** popcount and accumulation are unsigned. The nz width is sized for full-chunk density, so there is no overflow.
- **Wrap-around:** wr_chunk_count_i wrapping to 0 is a normal chunk change.

Test Plan:
1. **Full chunk write:** 4 beats to chunk 5, dat_count 0..3, each sparsemap with 16 ones, then valid=0.
   - chunk_ready_o[5]=1 two cycles after the last beat edge.
   - Reading chunk 5 beat 2 gives rd_valid_o one cycle later, data as written, rd_nz_count_o=64, rd_hit_o=1.
2. **Short last chunk:** 2 beats to chunk 7 (sparsemaps 0x3 and 0x1).
   - Read beat 3 returns sparsemap=0, data=0, nz=3.
3. **Back-to-back chunks:** chunk 0 beats 0..3 followed directly by chunk 1 beat 0.
   - Chunk 0 becomes ready without any idle cycle.
   - Chunk 1 becomes ready only after valid drops.
   - wr_err_o=0.
4. **Sequence error:** chunk 2 beats 0,1,3.
   - wr_err_o=1 after the third beat and stays set.
   - Chunk 2 beat_cnt=4.
5. **Collision and rewrite:**
   - Read chunk 5 beat 0 in the same cycle as a new beat-0 write to chunk 5: old data returned, rd_hit_o=1.
   - chunk_ready_o[5]=0 the next cycle.
6. **Reset/clear:** rst_i=0 mid-chunk -> all outputs 0; after release, reading previously ready chunks gives rd_hit_o=0. clr_i pulse -> chunk_ready_o=0 and wr_err_o=0.

Source files
------------

// File: rtl/sparse_chunk_sram_if.sv
// Bundle of the chunked sparse write stream and the beat-granular read port.
interface sparse_chunk_sram_if #(
    parameter int unsigned BUS_SIZE       = 64,
    parameter int unsigned DAT_SIZE       = 8,
    parameter int unsigned WR_DAT_CYC_NUM = 4,
    parameter int unsigned CHUNK_NUM      = 32
);
    localparam int unsigned DC_W = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1;
    localparam int unsigned CH_W = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1;
    localparam int unsigned NZ_W = $clog2(BUS_SIZE * WR_DAT_CYC_NUM + 1);
    localparam int unsigned DW   = BUS_SIZE * DAT_SIZE;

    logic                 wr_valid_i;
    logic [BUS_SIZE-1:0]  wr_sparsemap_i;
    logic [DW-1:0]        wr_nonzero_data_i;
    logic [DC_W-1:0]      wr_dat_count_i;
    logic [CH_W-1:0]      wr_chunk_count_i;
    logic                 rd_req_i;
    logic [CH_W-1:0]      rd_chunk_i;
    logic [DC_W-1:0]      rd_dat_count_i;
    logic                 rd_valid_o;
    logic [BUS_SIZE-1:0]  rd_sparsemap_o;
    logic [DW-1:0]        rd_nonzero_data_o;
    logic [NZ_W-1:0]      rd_nz_count_o;
    logic                 rd_hit_o;
    logic [CHUNK_NUM-1:0] chunk_ready_o;
    logic                 wr_err_o;

    modport master (
        output wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i, wr_dat_count_i, wr_chunk_count_i,
        output rd_req_i, rd_chunk_i, rd_dat_count_i,
        input  rd_valid_o, rd_sparsemap_o, rd_nonzero_data_o, rd_nz_count_o, rd_hit_o,
        input  chunk_ready_o, wr_err_o
    );

    modport slave (
        input  wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i, wr_dat_count_i, wr_chunk_count_i,
        input  rd_req_i, rd_chunk_i, rd_dat_count_i,
        output rd_valid_o, rd_sparsemap_o, rd_nonzero_data_o, rd_nz_count_o, rd_hit_o,
        output chunk_ready_o, wr_err_o
    );
endinterface

// File: rtl/sparse_chunk_sram.sv
// Per-chunk store for the sparse write stream: tracks beats, non-zero totals and readiness,
// flags malformed beat sequences and serves 1-cycle-latency beat reads.
module sparse_chunk_sram #(
    parameter int unsigned BUS_SIZE       = 64,
    parameter int unsigned DAT_SIZE       = 8,
    parameter int unsigned WR_DAT_CYC_NUM = 4,
    parameter int unsigned CHUNK_NUM      = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    sparse_chunk_sram_if.slave bus
);
    localparam int unsigned DC_W  = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1;
    localparam int unsigned CH_W  = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1;
    localparam int unsigned NZ_W  = $clog2(BUS_SIZE * WR_DAT_CYC_NUM + 1);
    localparam int unsigned BC_W  = $clog2(WR_DAT_CYC_NUM + 1);
    localparam int unsigned DW    = BUS_SIZE * DAT_SIZE;
    localparam int unsigned DEPTH = CHUNK_NUM * WR_DAT_CYC_NUM;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StIdle, StOpen} trk_state_e;

    logic            wr_valid;
    logic [CH_W-1:0] wr_chunk;
    logic [DC_W-1:0] wr_dc;
    logic [CH_W-1:0] rd_chunk;
    logic [DC_W-1:0] rd_dc;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;

    assign wr_valid = bus.wr_valid_i;
    assign wr_chunk = bus.wr_chunk_count_i;
    assign wr_dc    = bus.wr_dat_count_i;
    assign rd_chunk = bus.rd_chunk_i;
    assign rd_dc    = bus.rd_dat_count_i;
    assign wr_addr  = AW'(wr_chunk) * AW'(WR_DAT_CYC_NUM) + AW'(wr_dc);
    assign rd_addr  = AW'(rd_chunk) * AW'(WR_DAT_CYC_NUM) + AW'(rd_dc);

    logic [BUS_SIZE-1:0] sm_mem  [DEPTH];
    logic [DW-1:0]       dat_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_valid) begin
            sm_mem[wr_addr]  <= bus.wr_sparsemap_i;
            dat_mem[wr_addr] <= bus.wr_nonzero_data_i;
        end
    end

    logic [NZ_W-1:0] wr_pop;

    always_comb begin
        wr_pop = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            wr_pop = wr_pop + NZ_W'(bus.wr_sparsemap_i[i]);
        end
    end

    trk_state_e      state_q, state_d;
    logic [CH_W-1:0] open_chunk_q, open_chunk_d;
    logic [DC_W-1:0] last_beat_q, last_beat_d;
    logic [NZ_W-1:0] nz_acc_q, nz_acc_d;

    logic [CHUNK_NUM-1:0] ready_q;
    logic [BC_W-1:0]      beat_cnt_q [CHUNK_NUM];
    logic [NZ_W-1:0]      nz_cnt_q   [CHUNK_NUM];
    logic                 err_q;

    logic            open_vld;
    logic            same_chunk;
    logic            close_chunk;
    logic            commit;
    logic            seq_err;
    logic [BC_W-1:0] next_beat;

    assign open_vld    = (state_q == StOpen);
    assign same_chunk  = open_vld && (wr_chunk == open_chunk_q);
    assign close_chunk = open_vld && (!wr_valid || (wr_chunk != open_chunk_q));
    assign commit      = close_chunk && !clr_i;
    assign next_beat   = BC_W'(last_beat_q) + BC_W'(1);
    assign seq_err     = wr_valid && (wr_dc != '0) &&
                         !(same_chunk && (BC_W'(wr_dc) == next_beat));

    always_comb begin
        state_d      = state_q;
        open_chunk_d = open_chunk_q;
        last_beat_d  = last_beat_q;
        nz_acc_d     = nz_acc_q;
        if (wr_valid) begin
            state_d      = StOpen;
            open_chunk_d = wr_chunk;
            last_beat_d  = wr_dc;
            // A stray mid-chunk beat for a different chunk starts a fresh count.
            if ((wr_dc == '0) || !same_chunk) begin
                nz_acc_d = wr_pop;
            end else begin
                nz_acc_d = nz_acc_q + wr_pop;
            end
        end else begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            open_chunk_q <= '0;
            last_beat_q  <= '0;
            nz_acc_q     <= '0;
        end else begin
            state_q      <= state_d;
            open_chunk_q <= open_chunk_d;
            last_beat_q  <= last_beat_d;
            nz_acc_q     <= nz_acc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i || clr_i) begin
            ready_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < CHUNK_NUM; i++) begin
                beat_cnt_q[i] <= '0;
                nz_cnt_q[i]   <= '0;
            end
        end else begin
            if (commit) begin
                ready_q[open_chunk_q]    <= 1'b1;
                beat_cnt_q[open_chunk_q] <= next_beat;
                nz_cnt_q[open_chunk_q]   <= nz_acc_q;
            end
            // Commit and rewrite never target the same chunk: a close needs a chunk change.
            if (wr_valid && (wr_dc == '0)) begin
                ready_q[wr_chunk] <= 1'b0;
            end
            if (seq_err) begin
                err_q <= 1'b1;
            end
        end
    end

    logic                rd_valid_q;
    logic [BUS_SIZE-1:0] rd_sm_q;
    logic [DW-1:0]       rd_dat_q;
    logic [NZ_W-1:0]     rd_nz_q;
    logic                rd_hit_q;
    logic                rd_pad;

    assign rd_pad = (BC_W'(rd_dc) >= beat_cnt_q[rd_chunk]);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_valid_q <= 1'b0;
            rd_sm_q    <= '0;
            rd_dat_q   <= '0;
            rd_nz_q    <= '0;
            rd_hit_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_req_i;
            if (bus.rd_req_i) begin
                rd_sm_q  <= rd_pad ? '0 : sm_mem[rd_addr];
                rd_dat_q <= rd_pad ? '0 : dat_mem[rd_addr];
                rd_nz_q  <= nz_cnt_q[rd_chunk];
                rd_hit_q <= ready_q[rd_chunk];
            end
        end
    end

    assign bus.rd_valid_o        = rd_valid_q;
    assign bus.rd_sparsemap_o    = rd_sm_q;
    assign bus.rd_nonzero_data_o = rd_dat_q;
    assign bus.rd_nz_count_o     = rd_nz_q;
    assign bus.rd_hit_o          = rd_hit_q;
    assign bus.chunk_ready_o     = ready_q;
    assign bus.wr_err_o          = err_q;
endmodule
